// File: rtl/if_id_ctrl.sv
// if_id_ctrl: PC register, IF/ID pipeline register and fetch-side control
// for the 5-stage MIPS pipeline. It applies the hazard unit's stall and bubble
// requests and the branch redirect resolved in ID. It also keeps saturating
// stall/redirect counters and a sticky watchdog for illegally long stalls.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stall, idflush      hazard unit requests (hold IF/PC, bubble ID/EX)
//   branch_taken/target redirect resolved in ID
//   imem_addr/rdata     instruction memory (combinational read)
//   if_id_instr/pc4/valid  IF/ID register contents presented to ID
//   id_bubble           combinational: zero ID/EX control this cycle
//   cnt_clr             synchronous clear of counters and stall_err
//   stall_cnt/flush_cnt saturating performance counters
//   stall_err           sticky: stall held 3+ consecutive cycles
module if_id_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             idflush,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc4,
  output logic             if_id_valid,
  output logic             id_bubble,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             stall_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [1:0]       RUN_MAX = 2'd3;
  localparam logic [1:0]       RUN_ERR = 2'd2;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [1:0]       run_q, run_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_err_q, stall_err_d;
  logic [31:0]      pc_plus4;
  logic             redirect;

  // PC and IF/ID next state: stall holds, then redirect, then normal fetch
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    pc_plus4 = pc_q + 32'd4;
    redirect = ~stall & branch_taken;
    if (!stall) begin
      if (branch_taken) begin
        // fetched word is on the wrong path: load a sll-nop bubble instead
        pc_d    = branch_target;
        instr_d = 32'h0;
        pc4_d   = 32'h0;
        valid_d = 1'b0;
      end else begin
        pc_d    = pc_plus4;
        instr_d = imem_rdata;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
    end
  end

  // Stall run length, watchdog and performance counters; clear wins
  always_comb begin
    run_d       = run_q;
    stall_err_d = stall_err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      run_d       = 2'd0;
      stall_err_d = 1'b0;
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall) begin
        if (run_q != RUN_MAX) run_d = run_q + 2'd1;
        // third consecutive stall edge is longer than any legal hazard
        if (run_q == RUN_ERR) stall_err_d = 1'b1;
        if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
        run_d = 2'd0;
      end
      if (redirect && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= PC_RESET;
      instr_q     <= 32'h0;
      pc4_q       <= 32'h0;
      valid_q     <= 1'b0;
      run_q       <= 2'd0;
      stall_err_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      run_q       <= run_d;
      stall_err_q <= stall_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign stall_err   = stall_err_q;
  // zero-latency bubble request toward ID/EX
  assign id_bubble   = idflush | ~valid_q;

endmodule

// File: tb/tb_if_id_ctrl.sv
// Scoreboard bench for if_id_ctrl: stimulus pushes hand-computed expectations
// tagged with the cycle they apply to; a monitor pops and compares them on the
// falling edge.
module tb_if_id_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, idflush, branch_taken, cnt_clr;
  logic [31:0] branch_target;
  logic [31:0] imem_addr, imem_rdata, if_id_instr, if_id_pc4;
  logic        if_id_valid, id_bubble, stall_err;
  logic [15:0] stall_cnt, flush_cnt;

  // narrow-counter instance sharing the same stimulus
  logic [31:0] imem_addr2, imem_rdata2, if_id_instr2, if_id_pc42;
  logic        if_id_valid2, id_bubble2, stall_err2;
  logic [1:0]  stall_cnt2, flush_cnt2;

  always #5 clk = ~clk;

  assign imem_rdata  = 32'h2000_0000 + imem_addr;
  assign imem_rdata2 = 32'h2000_0000 + imem_addr2;

  if_id_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .idflush(idflush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .id_bubble(id_bubble), .cnt_clr(cnt_clr),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .stall_err(stall_err)
  );

  if_id_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .idflush(idflush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .if_id_instr(if_id_instr2), .if_id_pc4(if_id_pc42), .if_id_valid(if_id_valid2),
    .id_bubble(id_bubble2), .cnt_clr(cnt_clr),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2), .stall_err(stall_err2)
  );

  localparam int S_ADDR = 0, S_INSTR = 1, S_PC4 = 2, S_VALID = 3, S_BUB = 4,
                 S_SCNT = 5, S_FCNT = 6, S_ERR = 7, S_SCNT2 = 8;

  typedef struct {
    int          due;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_now(input int sig, input logic [31:0] val, input string name);
    exp_t e;
    e.due = cyc; e.sig = sig; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] actual(input int sig);
    case (sig)
      S_ADDR:  return imem_addr;
      S_INSTR: return if_id_instr;
      S_PC4:   return if_id_pc4;
      S_VALID: return 32'(if_id_valid);
      S_BUB:   return 32'(id_bubble);
      S_SCNT:  return 32'(stall_cnt);
      S_FCNT:  return 32'(flush_cnt);
      S_ERR:   return 32'(stall_err);
      S_SCNT2: return 32'(stall_cnt2);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // monitor: compare every expectation due by this cycle
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        exp_t e;
        logic [31:0] a;
        e = q.pop_front();
        a = actual(e.sig);
        n_tests++;
        if (a !== e.val) begin
          n_fail++;
          $display("FAIL %s (cycle %0d): got %h, expected %h", e.name, cyc, a, e.val);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; idflush = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; cnt_clr = 1'b0;
    step(); step();
    expect_now(S_ADDR, 32'h0, "rst_addr");
    expect_now(S_INSTR, 32'h0, "rst_instr");
    expect_now(S_VALID, 32'h0, "rst_valid");
    expect_now(S_BUB, 32'h1, "rst_bubble");
    expect_now(S_SCNT, 32'h0, "rst_stall_cnt");
    expect_now(S_FCNT, 32'h0, "rst_flush_cnt");
    expect_now(S_ERR, 32'h0, "rst_stall_err");
    rst_n = 1'b1;

    // free-run: three fetches
    step();
    expect_now(S_INSTR, 32'h2000_0000, "first_instr");
    expect_now(S_PC4, 32'h4, "first_pc4");
    step(); step();
    expect_now(S_ADDR, 32'hC, "run_addr");
    expect_now(S_INSTR, 32'h2000_0008, "run_instr");
    expect_now(S_PC4, 32'hC, "run_pc4");
    expect_now(S_BUB, 32'h0, "run_bubble");
    step();  // PC -> 0x10

    // load-use stall with idflush
    stall = 1'b1; idflush = 1'b1;
    expect_now(S_BUB, 32'h1, "lu_bubble");
    step();
    stall = 1'b0; idflush = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
    expect_now(S_ADDR, 32'h10, "lu_addr_hold");
    expect_now(S_INSTR, 32'h2000_000C, "lu_instr_hold");
    expect_now(S_PC4, 32'h10, "lu_pc4_hold");
    expect_now(S_SCNT, 32'h1, "lu_stall_cnt");
    expect_now(S_ERR, 32'h0, "lu_stall_err");

    // branch redirect from PC 0x10 to 0x40
    step();
    branch_taken = 1'b0;
    expect_now(S_ADDR, 32'h40, "br_addr");
    expect_now(S_VALID, 32'h0, "br_valid");
    expect_now(S_BUB, 32'h1, "br_bubble");
    expect_now(S_FCNT, 32'h1, "br_flush_cnt");
    step();
    expect_now(S_PC4, 32'h44, "br_target_pc4");
    expect_now(S_INSTR, 32'h2000_0040, "br_target_instr");

    // clear, then stall masks a branch for two cycles
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0; stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
    expect_now(S_SCNT, 32'h0, "clr_stall_cnt");
    expect_now(S_FCNT, 32'h0, "clr_flush_cnt");
    expect_now(S_ADDR, 32'h48, "clr_addr");
    step(); step();
    stall = 1'b0;
    expect_now(S_ADDR, 32'h48, "mask_addr");
    expect_now(S_INSTR, 32'h2000_0044, "mask_instr");
    expect_now(S_FCNT, 32'h0, "mask_flush_cnt");
    expect_now(S_SCNT, 32'h2, "mask_stall_cnt");
    expect_now(S_ERR, 32'h0, "mask_two_stall_legal");
    step();
    branch_taken = 1'b0;
    expect_now(S_ADDR, 32'h80, "unmask_redirect");
    expect_now(S_VALID, 32'h0, "unmask_valid");
    expect_now(S_FCNT, 32'h1, "unmask_flush_cnt");
    step();
    expect_now(S_ADDR, 32'h84, "unmask_once_addr");
    expect_now(S_FCNT, 32'h1, "unmask_once_cnt");

    // watchdog: three consecutive stalls
    stall = 1'b1;
    step(); step();
    expect_now(S_ERR, 32'h0, "wd_two");
    step();
    stall = 1'b0;
    expect_now(S_ERR, 32'h1, "wd_three");
    expect_now(S_SCNT, 32'h5, "wd_stall_cnt");
    expect_now(S_SCNT2, 32'h3, "sat_stall_cnt2");
    step();
    cnt_clr = 1'b1;
    expect_now(S_ERR, 32'h1, "wd_sticky");
    expect_now(S_ADDR, 32'h88, "wd_addr");
    step();
    cnt_clr = 1'b0;
    expect_now(S_ERR, 32'h0, "clr_err");
    expect_now(S_SCNT, 32'h0, "clr_stall_cnt2");
    expect_now(S_ADDR, 32'h8C, "clr_keeps_pc");

    // PC wrap
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    expect_now(S_ADDR, 32'hFFFF_FFFC, "wrap_pre");
    step();
    expect_now(S_ADDR, 32'h0, "wrap_addr");
    expect_now(S_INSTR, 32'h1FFF_FFFC, "wrap_instr");
    expect_now(S_PC4, 32'h0, "wrap_pc4");
    step();

    // async reset mid-cycle with a redirect pending
    branch_taken = 1'b1; branch_target = 32'h100;
    rst_n = 1'b0;
    #1;
    expect_now(S_ADDR, 32'h0, "arst_addr");
    expect_now(S_VALID, 32'h0, "arst_valid");
    expect_now(S_BUB, 32'h1, "arst_bubble");
    expect_now(S_INSTR, 32'h0, "arst_instr");
    step();
    rst_n = 1'b1; branch_taken = 1'b0;
    step();
    expect_now(S_ADDR, 32'h4, "post_rst_addr");
    expect_now(S_INSTR, 32'h2000_0000, "post_rst_instr");

    // bounded drain of the scoreboard
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
